// File: rtl/dl11_pkg.sv
// Shared definitions for the DL11 terminal: register offsets, CSR/RBUF bit
// positions and the RX/TX state encodings.
package dl11_pkg;

    localparam logic [1:0] ADR_RCSR = 2'd0;
    localparam logic [1:0] ADR_RBUF = 2'd1;
    localparam logic [1:0] ADR_XCSR = 2'd2;
    localparam logic [1:0] ADR_XBUF = 2'd3;

    localparam int CSR_DONE  = 7;
    localparam int CSR_READY = 7;
    localparam int CSR_IE    = 6;
    localparam int RBUF_ERR  = 15;
    localparam int RBUF_OVR  = 14;
    localparam int RBUF_FRM  = 13;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [15:0] csr_word(input logic flag, input logic ie);
        csr_word = {8'h00, flag, ie, 6'b000000};
    endfunction

endpackage

// File: rtl/dl11_rx.sv
// DL11 receiver: 2-flop synchroniser, 16x-oversampled RX FSM and shift register.
// Emits a one-cycle rx_valid pulse with the byte and its framing-error flag.
module dl11_rx
    import dl11_pkg::*;
(
    input  logic       mclkp,
    input  logic       RST,
    input  logic       tick,
    input  logic       uart_rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_frm
);

    logic [1:0] sync_r;
    logic       rx_s;
    rx_state_e  state_r, state_s;
    logic [3:0] tick_cnt_r, tick_cnt_s;
    logic [2:0] bit_cnt_r, bit_cnt_s;
    logic [7:0] shift_r, shift_s;
    logic [7:0] data_r, data_s;
    logic       valid_r, valid_s;
    logic       frm_r, frm_s;

    assign rx_s     = sync_r[1];
    assign rx_valid = valid_r;
    assign rx_data  = data_r;
    assign rx_frm   = frm_r;

    // Synchroniser, reset to the idle (mark) level
    always_ff @(posedge mclkp) begin
        if (RST) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], uart_rx};
        end
    end

    // RX state and datapath registers
    always_ff @(posedge mclkp) begin
        if (RST) begin
            state_r    <= RX_IDLE;
            tick_cnt_r <= 4'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            data_r     <= 8'h00;
            valid_r    <= 1'b0;
            frm_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            tick_cnt_r <= tick_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            data_r     <= data_s;
            valid_r    <= valid_s;
            frm_r      <= frm_s;
        end
    end

    // RX next state: start bit re-checked at mid-bit, then one sample per 16 ticks
    always_comb begin
        state_s    = state_r;
        tick_cnt_s = tick_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        data_s     = data_r;
        valid_s    = 1'b0;
        frm_s      = frm_r;
        if (tick) begin
            case (state_r)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state_s    = RX_START;
                        tick_cnt_s = 4'd0;
                    end else begin
                        state_s = RX_IDLE;
                    end
                end
                RX_START: begin
                    if (tick_cnt_r == 4'd7) begin
                        tick_cnt_s = 4'd0;
                        bit_cnt_s  = 3'd0;
                        state_s    = rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_cnt_s = tick_cnt_r + 4'd1;
                    end
                end
                RX_DATA: begin
                    if (tick_cnt_r == 4'd15) begin
                        tick_cnt_s = 4'd0;
                        shift_s    = {rx_s, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
                            state_s = RX_STOP;
                        end else begin
                            bit_cnt_s = bit_cnt_r + 3'd1;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + 4'd1;
                    end
                end
                RX_STOP: begin
                    if (tick_cnt_r == 4'd15) begin
                        tick_cnt_s = 4'd0;
                        valid_s    = 1'b1;
                        data_s     = shift_r;
                        frm_s      = ~rx_s;
                        state_s    = RX_IDLE;
                    end else begin
                        tick_cnt_s = tick_cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_s = RX_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

endmodule

// File: rtl/wb_dl11_term.sv
// DL11-style serial terminal (RCSR/RBUF/XCSR/XBUF) as a Wishbone classic slave.
// Define DL11_RXFIFO_EN to replace the single RBUF holding register by an RX FIFO.
module wb_dl11_term
    import dl11_pkg::*;
#(
    parameter int BAUD_DIV  = 27,
    parameter int FIFO_LOG2 = 2
) (
    input  logic        mclkp,
    input  logic        RST,
    input  logic [1:0]  wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    output logic        wb_ack_o,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq_rx,
    output logic        irq_tx
);

    localparam int            BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    logic [BW-1:0] baud_cnt_r;
    logic          tick_s;
    logic          ack_r, irq_rx_r, irq_tx_r, rx_ie_r, tx_ie_r, ready_r;
    logic [15:0]   dat_r, rd_data_s;
    logic          req_s, rd_s, wr_s, rbuf_rd_s, xbuf_wr_s, rcsr_wr_s, xcsr_wr_s;
    logic          rx_valid_s, rx_frm_s;
    logic [7:0]    rx_data_s;
    logic          done_s, ovr_s, head_frm_s;
    logic [7:0]    head_data_s;
    logic          unused_s;

    assign unused_s = ^{wb_dat_i[15:8], wb_sel_i[1]};

    assign tick_s    = (baud_cnt_r == BAUD_LAST);
    assign req_s     = wb_cyc_i & wb_stb_i & ~ack_r;
    assign rd_s      = req_s & ~wb_we_i;
    assign wr_s      = req_s & wb_we_i;
    assign rbuf_rd_s = rd_s & (wb_adr_i == ADR_RBUF);
    assign rcsr_wr_s = wr_s & (wb_adr_i == ADR_RCSR) & wb_sel_i[0];
    assign xcsr_wr_s = wr_s & (wb_adr_i == ADR_XCSR) & wb_sel_i[0];
    assign xbuf_wr_s = wr_s & (wb_adr_i == ADR_XBUF) & wb_sel_i[0] & ready_r;

    assign wb_ack_o = ack_r;
    assign wb_dat_o = dat_r;
    assign irq_rx   = irq_rx_r;
    assign irq_tx   = irq_tx_r;

    // Shared 16x baud tick
    always_ff @(posedge mclkp) begin
        if (RST || tick_s) begin
            baud_cnt_r <= '0;
        end else begin
            baud_cnt_r <= baud_cnt_r + BW'(1);
        end
    end

    dl11_rx u_rx (
        .mclkp    (mclkp),
        .RST      (RST),
        .tick     (tick_s),
        .uart_rx  (uart_rx),
        .rx_valid (rx_valid_s),
        .rx_data  (rx_data_s),
        .rx_frm   (rx_frm_s)
    );

`ifdef DL11_RXFIFO_EN
    localparam int DEPTH = 1 << FIFO_LOG2;

    logic [8:0]         mem_r [DEPTH];
    logic [FIFO_LOG2:0] wr_ptr_r, rd_ptr_r;
    logic               ovr_r, empty_s, full_s, push_s, pop_s;

    assign empty_s     = (wr_ptr_r == rd_ptr_r);
    assign full_s      = (wr_ptr_r[FIFO_LOG2] != rd_ptr_r[FIFO_LOG2]) &&
                         (wr_ptr_r[FIFO_LOG2-1:0] == rd_ptr_r[FIFO_LOG2-1:0]);
    assign push_s      = rx_valid_s & ~full_s;
    assign pop_s       = rbuf_rd_s & ~empty_s;
    assign done_s      = ~empty_s;
    assign ovr_s       = ovr_r;
    assign head_data_s = mem_r[rd_ptr_r[FIFO_LOG2-1:0]][7:0];
    assign head_frm_s  = mem_r[rd_ptr_r[FIFO_LOG2-1:0]][8];

    // RX FIFO; a byte arriving while full is dropped and flagged as overrun
    always_ff @(posedge mclkp) begin
        if (RST) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            ovr_r    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 9'h000;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[FIFO_LOG2-1:0]] <= {rx_frm_s, rx_data_s};
                wr_ptr_r <= wr_ptr_r + {{FIFO_LOG2{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{FIFO_LOG2{1'b0}}, 1'b1};
            end
            if (rx_valid_s && full_s) begin
                ovr_r <= 1'b1;
            end else if (rbuf_rd_s) begin
                ovr_r <= 1'b0;
            end
        end
    end
`else
    localparam int unused_fifo_log2 = FIFO_LOG2;

    logic [7:0] rbuf_r;
    logic       done_r, ovr_r, frm_r;

    assign done_s      = done_r;
    assign ovr_s       = ovr_r;
    assign head_data_s = rbuf_r;
    assign head_frm_s  = frm_r;

    // Single holding register: a new byte always overwrites, and beats a same-cycle read
    always_ff @(posedge mclkp) begin
        if (RST) begin
            rbuf_r <= 8'h00;
            done_r <= 1'b0;
            ovr_r  <= 1'b0;
            frm_r  <= 1'b0;
        end else if (rx_valid_s) begin
            rbuf_r <= rx_data_s;
            frm_r  <= rx_frm_s;
            done_r <= 1'b1;
            ovr_r  <= rbuf_rd_s ? 1'b0 : (ovr_r | done_r);
        end else if (rbuf_rd_s) begin
            done_r <= 1'b0;
            ovr_r  <= 1'b0;
            frm_r  <= 1'b0;
        end
    end
`endif

    tx_state_e  tx_state_r, tx_state_s;
    logic [3:0] tx_tick_r, tx_tick_s;
    logic [2:0] tx_bit_r, tx_bit_s;
    logic [7:0] tx_shift_r, tx_shift_s;
    logic       tx_line_r, tx_line_s, tx_done_s;

    assign uart_tx = tx_line_r;

    // TX registers; READY drops on an accepted XBUF write and returns after the stop bit
    always_ff @(posedge mclkp) begin
        if (RST) begin
            tx_state_r <= TX_IDLE;
            tx_tick_r  <= 4'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_line_r  <= 1'b1;
            ready_r    <= 1'b1;
        end else begin
            tx_state_r <= tx_state_s;
            tx_tick_r  <= tx_tick_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            tx_line_r  <= tx_line_s;
            if (xbuf_wr_s) begin
                ready_r <= 1'b0;
            end else if (tx_done_s) begin
                ready_r <= 1'b1;
            end
        end
    end

    // TX next state; a pending byte (READY=0 in IDLE) starts on the next tick
    always_comb begin
        tx_state_s = tx_state_r;
        tx_tick_s  = tx_tick_r;
        tx_bit_s   = tx_bit_r;
        tx_line_s  = tx_line_r;
        tx_done_s  = 1'b0;
        if (xbuf_wr_s) begin
            tx_shift_s = wb_dat_i[7:0];
        end else begin
            tx_shift_s = tx_shift_r;
        end
        if (tick_s) begin
            case (tx_state_r)
                TX_IDLE: begin
                    if (!ready_r) begin
                        tx_state_s = TX_START;
                        tx_tick_s  = 4'd0;
                        tx_line_s  = 1'b0;
                    end else begin
                        tx_line_s = 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_tick_r == 4'd15) begin
                        tx_state_s = TX_DATA;
                        tx_tick_s  = 4'd0;
                        tx_bit_s   = 3'd0;
                        tx_line_s  = tx_shift_r[0];
                    end else begin
                        tx_tick_s = tx_tick_r + 4'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_tick_r == 4'd15) begin
                        tx_tick_s = 4'd0;
                        if (tx_bit_r == 3'd7) begin
                            tx_state_s = TX_STOP;
                            tx_line_s  = 1'b1;
                        end else begin
                            tx_bit_s   = tx_bit_r + 3'd1;
                            tx_shift_s = {1'b0, tx_shift_r[7:1]};
                            tx_line_s  = tx_shift_r[1];
                        end
                    end else begin
                        tx_tick_s = tx_tick_r + 4'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_tick_r == 4'd15) begin
                        tx_state_s = TX_IDLE;
                        tx_tick_s  = 4'd0;
                        tx_done_s  = 1'b1;
                    end else begin
                        tx_tick_s = tx_tick_r + 4'd1;
                    end
                end
                default: begin
                    tx_state_s = TX_IDLE;
                    tx_line_s  = 1'b1;
                end
            endcase
        end else begin
            tx_state_s = tx_state_r;
        end
    end

    // Read mux, sampled before any read side effect takes place
    always_comb begin
        rd_data_s = 16'h0000;
        case (wb_adr_i)
            ADR_RCSR: rd_data_s = csr_word(done_s, rx_ie_r);
            ADR_RBUF: rd_data_s = {ovr_s | head_frm_s, ovr_s, head_frm_s, 5'b00000, head_data_s};
            ADR_XCSR: rd_data_s = csr_word(ready_r, tx_ie_r);
            ADR_XBUF: rd_data_s = 16'h0000;
            default:  rd_data_s = 16'h0000;
        endcase
    end

    // Bus response, interrupt enables and registered interrupt requests
    always_ff @(posedge mclkp) begin
        if (RST) begin
            ack_r    <= 1'b0;
            dat_r    <= 16'h0000;
            rx_ie_r  <= 1'b0;
            tx_ie_r  <= 1'b0;
            irq_rx_r <= 1'b0;
            irq_tx_r <= 1'b0;
        end else begin
            ack_r    <= req_s;
            dat_r    <= rd_s ? rd_data_s : 16'h0000;
            if (rcsr_wr_s) begin
                rx_ie_r <= wb_dat_i[CSR_IE];
            end
            if (xcsr_wr_s) begin
                tx_ie_r <= wb_dat_i[CSR_IE];
            end
            irq_rx_r <= rx_ie_r & done_s;
            irq_tx_r <= tx_ie_r & ready_r;
        end
    end

endmodule
